// File: rtl/karatsuba_seq_mult.sv
// Sequential Karatsuba multiplier: one shared (HALF_W+1)^2 multiplier, three passes.
// Ports: clk, rst_n, in_valid/in_ready/IN1/IN2 in, out_valid/out_ready/OUTPUT out, busy.
module karatsuba_seq_mult #(
  parameter int HALF_W = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   IN1,
  input  logic [2*HALF_W-1:0]   IN2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*HALF_W-1:0]   OUTPUT,
  output logic                  busy
);

  localparam int FW = 2 * HALF_W;
  localparam int PW = FW + 2;
  localparam int OW = 4 * HALF_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_HI,
    S_MUL_LO,
    S_MUL_MID,
    S_COMBINE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [HALF_W-1:0] a_h_q, a_h_d;
  logic [HALF_W-1:0] a_l_q, a_l_d;
  logic [HALF_W-1:0] b_h_q, b_h_d;
  logic [HALF_W-1:0] b_l_q, b_l_d;
  logic [FW-1:0]     p_hi_q, p_hi_d;
  logic [FW-1:0]     p_lo_q, p_lo_d;
  logic [PW-1:0]     p_mid_q, p_mid_d;
  logic [OW-1:0]     out_q, out_d;

  logic [HALF_W:0]   mul_a;
  logic [HALF_W:0]   mul_b;
  logic [PW-1:0]     mul_p;
  logic [PW-1:0]     mid;
  logic [OW-1:0]     sum;

  // Operand select for the single shared multiplier
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (1'b1)
      state_q == S_MUL_HI: begin
        mul_a = {1'b0, a_h_q};
        mul_b = {1'b0, b_h_q};
      end
      state_q == S_MUL_LO: begin
        mul_a = {1'b0, a_l_q};
        mul_b = {1'b0, b_l_q};
      end
      state_q == S_MUL_MID: begin
        mul_a = {1'b0, a_h_q} + {1'b0, a_l_q};
        mul_b = {1'b0, b_h_q} + {1'b0, b_l_q};
      end
      default: ;
    endcase
  end

  assign mul_p = PW'(mul_a) * PW'(mul_b);

  // Cross term is never negative; it fits in FW+1 bits
  assign mid = p_mid_q - PW'(p_hi_q) - PW'(p_lo_q);
  assign sum = {p_hi_q, p_lo_q} + (OW'(mid) << HALF_W);

  always_comb begin
    state_d = state_q;
    a_h_d   = a_h_q;
    a_l_d   = a_l_q;
    b_h_d   = b_h_q;
    b_l_d   = b_l_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_mid_d = p_mid_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_h_d   = IN1[FW-1:HALF_W];
          a_l_d   = IN1[HALF_W-1:0];
          b_h_d   = IN2[FW-1:HALF_W];
          b_l_d   = IN2[HALF_W-1:0];
          state_d = S_MUL_HI;
        end
      end
      S_MUL_HI: begin
        p_hi_d  = mul_p[FW-1:0];
        state_d = S_MUL_LO;
      end
      S_MUL_LO: begin
        p_lo_d  = mul_p[FW-1:0];
        state_d = S_MUL_MID;
      end
      S_MUL_MID: begin
        p_mid_d = mul_p;
        state_d = S_COMBINE;
      end
      S_COMBINE: begin
        out_d   = sum;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_h_q   <= '0;
      a_l_q   <= '0;
      b_h_q   <= '0;
      b_l_q   <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_mid_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_h_q   <= a_h_d;
      a_l_q   <= a_l_d;
      b_h_q   <= b_h_d;
      b_l_q   <= b_l_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_mid_q <= p_mid_d;
      out_q   <= out_d;
    end
  end

  // Gated by rst_n so nothing is offered while reset is held
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign OUTPUT    = out_q;

endmodule

// File: tb/tb_karatsuba_seq_mult.sv
// Self-checking bench for karatsuba_seq_mult (HALF_W=18).
// Randomized and directed scenarios against a plain-arithmetic product model.
module tb_karatsuba_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [35:0] IN1 = '0;
  logic [35:0] IN2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] OUTPUT;
  logic        busy;

  int total = 0;
  int bad = 0;

  karatsuba_seq_mult #(.HALF_W(18)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .IN1(IN1),
    .IN2(IN2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .OUTPUT(OUTPUT),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] ref_mul(logic [35:0] a, logic [35:0] b);
    logic [71:0] x;
    logic [71:0] y;
    x = 72'(a);
    y = 72'(b);
    return x * y;
  endfunction

  function automatic logic [17:0] pick_half();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 5)
      0: return 18'h0;
      1: return 18'h1;
      2: return 18'h3FFFF;
      3: return 18'h20000;
      default: return r[17:0];
    endcase
  endfunction

  function automatic logic [35:0] pick();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom % 8)
      0: return 36'h0;
      1: return 36'h1;
      2: return 36'h3FFFF;
      3: return 36'h40000;
      4: return 36'hFFFFFFFFF;
      5: return {pick_half(), pick_half()};
      default: return r[35:0];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: issue one operation, scramble inputs, count edges to DONE
  task automatic do_op(input logic [35:0] a, input logic [35:0] b,
                       output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    IN1 = a;
    IN2 = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    IN1 = pick();
    IN2 = pick();
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got rdy=%b vld=%b busy=%b want 0 0 0",
               in_ready, out_valid, busy);
    end
    total++;
    if (OUTPUT !== 72'h0) begin
      bad++;
      $display("FAIL reset_output got %h want 0", OUTPUT);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    logic [35:0] va[3];
    logic [35:0] vb[3];
    logic [71:0] vr[3];
    int lat;
    va[0] = 36'hFFFFFFFFF; vb[0] = 36'hFFFFFFFFF; vr[0] = 72'hFF_FFFF_FFE0_0000_0001;
    va[1] = 36'h000040000; vb[1] = 36'h000040000; vr[1] = 72'h10_0000_0000;
    va[2] = 36'h123456789; vb[2] = 36'h2;         vr[2] = 72'h2_468A_CF12;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], lat);
      total++;
      if (lat !== 4) begin
        bad++;
        $display("FAIL dir_latency[%0d] got %0d want 4", i, lat);
      end
      total++;
      if (OUTPUT !== vr[i]) begin
        bad++;
        $display("FAIL dir_product[%0d] got %h want %h", i, OUTPUT, vr[i]);
      end
      step();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL dir_one_cycle[%0d] got vld=%b rdy=%b want 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [71:0] exp;
    int errs;
    exp = ref_mul(36'h9ABCDEF01, 36'h76543210F);
    out_ready = 1'b0;
    do_op(36'h9ABCDEF01, 36'h76543210F, lat);
    total++;
    if (lat !== 4 || OUTPUT !== exp) begin
      bad++;
      $display("FAIL bp_first got lat=%0d out=%h want 4 %h", lat, OUTPUT, exp);
    end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      IN1 = pick();
      IN2 = pick();
      step();
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
          OUTPUT !== exp) begin
        bad++;
        $display("FAIL bp_stall[%0d] got vld=%b busy=%b rdy=%b out=%h want 1 1 0 %h",
                 i, out_valid, busy, in_ready, OUTPUT, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got vld=%b rdy=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
    step();
    step();
    total++;
    if (OUTPUT !== exp || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_retain got out=%h busy=%b want %h 0", OUTPUT, busy, exp);
    end
  endtask

  task automatic test_hold_valid();
    logic [35:0] a1, b1, a2, b2;
    int n;
    a1 = pick(); b1 = pick();
    a2 = 36'h00000ABCD; b2 = 36'h0000F0F0F;
    out_ready = 1'b0;
    IN1 = a1;
    IN2 = b1;
    in_valid = 1'b1;
    step();
    IN1 = a2;
    IN2 = b2;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n !== 4 || OUTPUT !== ref_mul(a1, b1)) begin
      bad++;
      $display("FAIL hold_first got n=%0d out=%h want 4 %h",
               n, OUTPUT, ref_mul(a1, b1));
    end
    out_ready = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_idle got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n !== 4 || OUTPUT !== ref_mul(a2, b2)) begin
      bad++;
      $display("FAIL hold_second got n=%0d out=%h want 4 %h",
               n, OUTPUT, ref_mul(a2, b2));
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    out_ready = 1'b1;
    IN1 = 36'h7;
    IN2 = 36'h9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (OUTPUT !== 72'h0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async got out=%h vld=%b busy=%b rdy=%b want 0 0 0 0",
               OUTPUT, out_valid, busy, in_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || OUTPUT !== 72'h0) begin
      bad++;
      $display("FAIL rmid_release got rdy=%b out=%h want 1 0", in_ready, OUTPUT);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rmid_no_pulse got %0d pulses want 0", seen);
    end
    do_op(36'h3, 36'h5, lat);
    total++;
    if (lat !== 4 || OUTPUT !== 72'd15) begin
      bad++;
      $display("FAIL rmid_next got lat=%0d out=%h want 4 f", lat, OUTPUT);
    end
    step();
  endtask

  task automatic test_random();
    logic [71:0] q[$];
    logic [71:0] exp;
    int sent, got, cyc;
    int n_ops;
    n_ops = 3000;
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < n_ops && cyc < n_ops * 30) begin
      in_valid = (sent < n_ops) && ($urandom % 4 != 0);
      IN1 = pick();
      IN2 = pick();
      out_ready = ($urandom % 3 != 0);
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra got unexpected %h", OUTPUT);
        end else begin
          exp = q.pop_front();
          got++;
          if (OUTPUT !== exp) begin
            bad++;
            $display("FAIL rand_product[%0d] got %h want %h", got, OUTPUT, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_mul(IN1, IN2));
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (got !== n_ops || q.size() !== 0) begin
      bad++;
      $display("FAIL rand_count got %0d left %0d want %0d 0",
               got, q.size(), n_ops);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_hold_valid();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
